// File: rtl/minisys_pkg.sv
// minisys_pkg: shared FSM encoding, cause codes and vector defaults for the MiniSys-1A fetch stage
package minisys_pkg;
    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, TRAP = 2'd2, HALT = 2'd3} state_t;
    localparam logic [4:0] CAUSE_ADEL = 5'd4;
    localparam logic [4:0] CAUSE_SYS = 5'd8;
    localparam logic [4:0] CAUSE_BP = 5'd9;
    localparam logic [4:0] CAUSE_OV = 5'd12;
    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VEC = 32'h0000_F000;
    function automatic logic [31:0] align4(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/pc_reg.sv
// pc_reg: 32-bit register with synchronous reset to a parameter value and load enable
module pc_reg #(
    parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] d,
    output logic [31:0] q
);
    always_ff @(posedge clk)
        if (rst) q <= RST_VAL;
        else if (en) q <= d;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC selection, fetch-valid/flush strobes and EPC/Cause capture
module pc_sequencer
    import minisys_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
    parameter logic [31:0] EXC_VEC = DEF_EXC_VEC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        halt,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        eret,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        if_valid,
    output logic        flush,
    output logic [31:0] epc,
    output logic [4:0]  cause,
    output logic [1:0]  state
);
    state_t st;
    logic go, jr_bad, take_exc, pc_en;
    logic [31:0] pc_next;
    assign state = st;
    assign pc_plus4 = pc + 32'd4;
    // halt outranks every redirect; only exc_req beats it
    assign go = ~halt & ~stall;
    assign jr_bad = jr & (jr_target[1:0] != 2'b00);
    assign take_exc = exc_req | (go & ~eret & jr_bad);
    assign pc_en = (st == RUN) & (take_exc | go);
    assign pc_next = take_exc ? EXC_VEC :
                     eret     ? epc :
                     jr       ? jr_target :
                     jmp      ? align4(jmp_target) :
                     br_taken ? align4(br_target) : pc_plus4;
    pc_reg #(.RST_VAL(RESET_VEC)) u_pc (
        .clk(clk), .rst(rst), .en(pc_en), .d(pc_next), .q(pc)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= BOOT;
            flush <= 1'b0;
            if_valid <= 1'b0;
            epc <= 32'h0;
            cause <= 5'h0;
        end else begin
            case (st)
                BOOT, TRAP: begin
                    st <= RUN;
                    flush <= 1'b0;
                    if_valid <= 1'b1;
                end
                RUN: begin
                    if (take_exc) begin
                        st <= TRAP;
                        flush <= 1'b1;
                        if_valid <= 1'b0;
                        epc <= exc_req ? exc_pc : jr_target;
                        cause <= exc_req ? exc_code : CAUSE_ADEL;
                    end else if (halt) begin
                        st <= HALT;
                        flush <= 1'b0;
                        if_valid <= 1'b0;
                    end else begin
                        flush <= go & (eret | jr | jmp | br_taken);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the MiniSys-1A CPU fetch stage. Owns the 32-bit PC register and decides its next value each cycle: sequential advance, stall hold, branch/jump/jr redirect, exception entry and ERET return. It also generates the fetch-valid and flush strobes, and captures EPC/Cause for the CP0 logic.

## Interface
Parameters:
- RESET_VEC, 32'h0000_0000, PC value loaded by reset
- EXC_VEC, 32'h0000_F000, PC value on exception entry

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- stall  in  1  hold PC (hazard or memory wait)
- halt  in  1  enter HALT; only rst exits
- br_taken  in  1  conditional branch resolved taken
- br_target  in  32  branch destination
- jmp  in  1  j/jal
- jmp_target  in  32  jump destination
- jr  in  1  jr/jalr
- jr_target  in  32  register-indirect destination
- exc_req  in  1  exception/interrupt request from pipeline
- exc_code  in  5  cause code for exc_req
- exc_pc  in  32  faulting-instruction PC
- eret  in  1  return from exception
- pc  out  32  current fetch PC
- pc_plus4  out  32  pc + 4, wraps modulo 2^32
- if_valid  out  1  fetch at pc is architecturally valid
- flush  out  1  discard the instruction in IF/ID
- epc  out  32  saved exception PC
- cause  out  5  saved exception code
- state  out  2  FSM state, for debug

## Operation
- FSM states: BOOT=0, RUN=1, TRAP=2, HALT=3.
- BOOT is the one cycle after rst: pc=RESET_VEC, if_valid=0. It always goes to RUN. PC is not advanced, so the first fetch is RESET_VEC.
- RUN next-PC priority, highest first:
  - exc_req (wins even during stall)
  - eret
  - jr
  - jmp
  - br_taken
  - stall (hold)
  - pc+4
- Redirect requesters hold their inputs while stall=1. A redirect is not taken under stall. Exception is the only exception to this.
- Misaligned jr (jr_target[1:0]!=0): treated as an internal exception. cause<=5'd4 (AdEL), epc<=jr_target, pc<=EXC_VEC. It takes effect only if exc_req is low that cycle.
- br_target and jmp_target: bits [1:0] are forced to 00.
- Exception entry from RUN: epc<=exc_pc, cause<=exc_code, pc<=EXC_VEC, go to TRAP.
- TRAP lasts exactly one cycle:
  - flush=1, if_valid=0, pc stays EXC_VEC.
  - exc_req, eret and redirects are ignored (no nesting).
  - Go to RUN.
- eret: pc<=epc, flush pulses, epc and cause are unchanged.
- halt (in RUN, lowest priority after exc_req) goes to HALT. In HALT: pc frozen, if_valid=0, flush=0, all inputs ignored.

## Timing
- Reset values: pc=RESET_VEC, pc_plus4=RESET_VEC+4, epc=0, cause=0, flush=0, if_valid=0, state=BOOT.
- All outputs are registered except pc_plus4, which is combinational from pc.
- Redirect sampled at edge N: pc=target and flush=1 during cycle N+1. flush is a single-cycle pulse.
- Back-to-back redirects give consecutive flush pulses.
- Exception at edge N: pc=EXC_VEC and state=TRAP in cycle N+1; state=RUN and first valid fetch at EXC_VEC in cycle N+2.
- stall=1 at edge N: pc unchanged in N+1, if_valid unchanged.
- rst has priority over every input, in every state, mid-operation included.
- PC arithmetic is 32-bit unsigned. 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.

## Structure
- Shared package `minisys_pkg`: state encoding (BOOT/RUN/TRAP/HALT), cause code constants (AdEL=4, Sys=8, Bp=9, Ov=12), RESET_VEC/EXC_VEC defaults.
- One sub-module: `pc_reg`, a 32-bit register with synchronous active-high reset to a parameter value and a load enable. pc_sequencer computes next-PC and the enable.

## Test plan
- Reset, then 3 free-run cycles: pc = 0 (BOOT), 0 (first valid), 4, 8; flush=0 throughout.
- At pc=0x10, br_taken=1, br_target=0x43 → next pc=0x40, flush=1 for one cycle, then pc=0x44.
- stall=1 with jmp=1, jmp_target=0x100 for 2 cycles, then stall=0 → pc held 2 cycles, then 0x100.
- exc_req=1, exc_code=12, exc_pc=0x20, concurrent stall=1 and eret=1 → pc=0xF000, state TRAP for 1 cycle, epc=0x20, cause=12. A second exc_req during TRAP is ignored. Later eret → pc=0x20, flush pulse.
- jr=1, jr_target=0x202 → pc=0xF000, epc=0x202, cause=4.
- At pc=0xFFFF_FFFC free run → pc=0. halt=1 → pc frozen 5 cycles, if_valid=0. rst mid-HALT → BOOT, pc=0.
